// File: rtl/xbar_pipe.sv
// Pipelined NUM_PORT x NUM_PORT crossbar: each output picks one input, re-heads
// the flit with that output's turn field, and registers it through 1 or 2 stages.
module xbar_pipe #(
    parameter  int NUM_PORT    = 5,
    parameter  int DATA_WIDTH  = 64,
    parameter  int TB_WIDTH    = 7,
    parameter  int PIPE_STAGES = 1,
    localparam int IR_WIDTH    = DATA_WIDTH + (NUM_PORT-1)*TB_WIDTH,
    localparam int SEL_WIDTH   = $clog2(NUM_PORT+1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_PORT*IR_WIDTH-1:0]   in_flat,
    input  logic [NUM_PORT-1:0]            in_valid,
    input  logic [NUM_PORT*SEL_WIDTH-1:0]  sel_flat,
    input  logic                           stall,
    output logic [NUM_PORT*DATA_WIDTH-1:0] out_flat,
    output logic [NUM_PORT-1:0]            out_valid,
    output logic                           sel_err,
    input  logic                           err_clr
);

    logic [NUM_PORT*DATA_WIDTH-1:0] w_data_p0;
    logic [NUM_PORT-1:0]            w_vld_p0;
    logic [NUM_PORT-1:0]            w_bad_p0;

    // Stage 0: per-output select and re-head; data forced to zero when not valid
    for (genvar o = 0; o < NUM_PORT; o++) begin : g_out
        logic [SEL_WIDTH-1:0]  w_sel;
        logic [DATA_WIDTH-1:0] w_dat;
        logic                  w_vld;

        assign w_sel = sel_flat[o*SEL_WIDTH +: SEL_WIDTH];

        if (o < NUM_PORT-1) begin : g_sub
            always_comb begin
                w_dat = '0;
                w_vld = 1'b0;
                for (int p = 0; p < NUM_PORT; p++) begin
                    if (w_sel == SEL_WIDTH'(p) && in_valid[p]) begin
                        w_vld = 1'b1;
                        w_dat = {in_flat[p*IR_WIDTH + DATA_WIDTH + o*TB_WIDTH +: TB_WIDTH],
                                 in_flat[p*IR_WIDTH +: DATA_WIDTH-TB_WIDTH]};
                    end
                end
            end
        end else begin : g_local
            // Local ejection keeps the base flit untouched
            always_comb begin
                w_dat = '0;
                w_vld = 1'b0;
                for (int p = 0; p < NUM_PORT; p++) begin
                    if (w_sel == SEL_WIDTH'(p) && in_valid[p]) begin
                        w_vld = 1'b1;
                        w_dat = in_flat[p*IR_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end

        assign w_data_p0[o*DATA_WIDTH +: DATA_WIDTH] = w_dat;
        assign w_vld_p0[o] = w_vld;
        assign w_bad_p0[o] = (w_sel > SEL_WIDTH'(NUM_PORT));
    end

    // Stage 1
    logic [NUM_PORT*DATA_WIDTH-1:0] r_data_p1;
    logic [NUM_PORT-1:0]            r_vld_p1;
    logic                           r_sel_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_p1 <= '0;
            r_vld_p1  <= '0;
        end else if (!stall) begin
            r_data_p1 <= w_data_p0;
            r_vld_p1  <= w_vld_p0;
        end
    end

    // A new illegal select outranks a coincident clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_err <= 1'b0;
        end else if (!stall && (|w_bad_p0)) begin
            r_sel_err <= 1'b1;
        end else if (err_clr) begin
            r_sel_err <= 1'b0;
        end
    end

    assign sel_err = r_sel_err;

    // Stage 2 (optional)
    if (PIPE_STAGES == 2) begin : g_pipe2
        logic [NUM_PORT*DATA_WIDTH-1:0] r_data_p2;
        logic [NUM_PORT-1:0]            r_vld_p2;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_data_p2 <= '0;
                r_vld_p2  <= '0;
            end else if (!stall) begin
                r_data_p2 <= r_data_p1;
                r_vld_p2  <= r_vld_p1;
            end
        end

        assign out_flat  = r_data_p2;
        assign out_valid = r_vld_p2;
    end else if (PIPE_STAGES == 1) begin : g_pipe1
        assign out_flat  = r_data_p1;
        assign out_valid = r_vld_p1;
    end else begin : g_pipe_bad
        $error("xbar_pipe: PIPE_STAGES must be 1 or 2");
    end

endmodule

// File: tb/tb_xbar_pipe.sv
// Bench for xbar_pipe: a 1-stage and a 2-stage instance share stimulus and are
// compared against a transaction-history model of the crossbar.
module tb_xbar_pipe;
    localparam int N   = 5;
    localparam int DW  = 64;
    localparam int TBW = 7;
    localparam int IRW = DW + (N-1)*TBW;
    localparam int SW  = 3;

    typedef struct packed {
        logic [N*DW-1:0] d;
        logic [N-1:0]    v;
    } xact_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N*IRW-1:0] in_flat = '0;
    logic [N-1:0]     in_valid = '0;
    logic [N*SW-1:0]  sel_flat = {N{3'd5}};
    logic             stall = 1'b0;
    logic             err_clr = 1'b0;
    logic [N*DW-1:0]  o_flat1, o_flat2;
    logic [N-1:0]     o_vld1, o_vld2;
    logic             o_err1, o_err2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    xbar_pipe #(.NUM_PORT(N), .DATA_WIDTH(DW), .TB_WIDTH(TBW), .PIPE_STAGES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_flat(in_flat), .in_valid(in_valid),
        .sel_flat(sel_flat), .stall(stall), .out_flat(o_flat1), .out_valid(o_vld1),
        .sel_err(o_err1), .err_clr(err_clr));

    xbar_pipe #(.NUM_PORT(N), .DATA_WIDTH(DW), .TB_WIDTH(TBW), .PIPE_STAGES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_flat(in_flat), .in_valid(in_valid),
        .sel_flat(sel_flat), .stall(stall), .out_flat(o_flat2), .out_valid(o_vld2),
        .sel_err(o_err2), .err_clr(err_clr));

    // Reference: what the crossbar should deliver for one set of inputs
    function automatic void model_xbar(input logic [N*IRW-1:0] fi, input logic [N-1:0] vi,
                                       input logic [N*SW-1:0] si, output xact_t t, output logic bad);
        logic [IRW-1:0] src;
        int s;
        t = '0;
        bad = 1'b0;
        for (int o = 0; o < N; o++) begin
            s = int'(si[o*SW +: SW]);
            if (s > N) bad = 1'b1;
            if (s < N && vi[s]) begin
                src = fi[s*IRW +: IRW];
                t.v[o] = 1'b1;
                if (o < N-1) t.d[o*DW +: DW] = {src[DW+o*TBW +: TBW], src[DW-TBW-1:0]};
                else         t.d[o*DW +: DW] = src[DW-1:0];
            end
        end
    endfunction

    // Accepted transactions, newest first; output k stages deep shows entry k-1
    xact_t hist[$];
    logic  exp_err = 1'b0;

    always @(posedge clk or negedge rst_n) begin : mdl
        xact_t t;
        logic  bad;
        if (!rst_n) begin
            hist.delete();
            exp_err <= 1'b0;
        end else begin
            model_xbar(in_flat, in_valid, sel_flat, t, bad);
            if (!stall) begin
                hist.push_front(t);
                if (hist.size() > 2) void'(hist.pop_back());
            end
            if (!stall && bad) exp_err <= 1'b1;
            else if (err_clr)  exp_err <= 1'b0;
        end
    end

    function automatic xact_t exp_at(input int k);
        return (hist.size() > k) ? hist[k] : xact_t'(0);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_in();
        logic [479:0] tmp;
        for (int i = 0; i < 15; i++) tmp[i*32 +: 32] = $urandom;
        in_flat = tmp[N*IRW-1:0];
    endtask

    task automatic set_sel(input int s0, input int s1, input int s2, input int s3, input int s4);
        sel_flat = {3'(s4), 3'(s3), 3'(s2), 3'(s1), 3'(s0)};
    endtask

    task automatic load_pattern();
        logic [IRW-1:0] w;
        for (int p = 0; p < N; p++) begin
            w[DW-1:0] = {$urandom, $urandom};
            for (int o = 0; o < N-1; o++) w[DW+o*TBW +: TBW] = 7'(16 + o);
            in_flat[p*IRW +: IRW] = w;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests += 3;
        if (o_flat1 !== '0 || o_vld1 !== '0) begin
            n_fail++; $display("FAIL reset_p1: got v=%h d=%h, want all zero", o_vld1, o_flat1);
        end
        if (o_flat2 !== '0 || o_vld2 !== '0) begin
            n_fail++; $display("FAIL reset_p2: got v=%h d=%h, want all zero", o_vld2, o_flat2);
        end
        if (o_err1 !== 1'b0 || o_err2 !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: got %b/%b, want 0/0", o_err1, o_err2);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_unicast();
        logic [IRW-1:0] in0, in1;
        xact_t e1;
        load_pattern();
        in_valid = '1;
        set_sel(1, 2, 3, 4, 0);
        in0 = in_flat[0 +: IRW];
        in1 = in_flat[IRW +: IRW];
        tick();
        e1 = exp_at(0);
        n_tests += 5;
        if (o_flat1[63:57] !== 7'h10) begin
            n_fail++; $display("FAIL unicast_field0: got %h, want 10", o_flat1[63:57]);
        end
        if (o_flat1[56:0] !== in1[56:0]) begin
            n_fail++; $display("FAIL unicast_base0: got %h, want %h", o_flat1[56:0], in1[56:0]);
        end
        if (o_flat1[4*DW +: DW] !== in0[63:0]) begin
            n_fail++; $display("FAIL unicast_local: got %h, want %h", o_flat1[4*DW +: DW], in0[63:0]);
        end
        if (o_vld1 !== 5'h1f) begin
            n_fail++; $display("FAIL unicast_valid: got %h, want 1f", o_vld1);
        end
        if ({o_vld1, o_flat1} !== {e1.v, e1.d}) begin
            n_fail++; $display("FAIL unicast_model: got v=%h d=%h want v=%h d=%h", o_vld1, o_flat1, e1.v, e1.d);
        end
    endtask

    task automatic test_multicast();
        logic [IRW-1:0] in2;
        xact_t e1, e2;
        load_pattern();
        in_valid = 5'b00100;
        set_sel(2, 2, 2, 5, 2);
        in2 = in_flat[2*IRW +: IRW];
        tick();
        e1 = exp_at(0);
        e2 = exp_at(1);
        n_tests += 6;
        if (o_vld1 !== 5'b10111) begin
            n_fail++; $display("FAIL mcast_valid: got %b, want 10111", o_vld1);
        end
        if (o_flat1[3*DW +: DW] !== '0) begin
            n_fail++; $display("FAIL mcast_idle: got %h, want 0", o_flat1[3*DW +: DW]);
        end
        if (o_flat1[4*DW +: DW] !== in2[63:0]) begin
            n_fail++; $display("FAIL mcast_local: got %h, want %h", o_flat1[4*DW +: DW], in2[63:0]);
        end
        if (o_flat1[DW +: DW] !== {7'h11, in2[56:0]}) begin
            n_fail++; $display("FAIL mcast_out1: got %h, want %h", o_flat1[DW +: DW], {7'h11, in2[56:0]});
        end
        if ({o_vld1, o_flat1} !== {e1.v, e1.d}) begin
            n_fail++; $display("FAIL mcast_p1: got v=%h d=%h want v=%h d=%h", o_vld1, o_flat1, e1.v, e1.d);
        end
        if ({o_vld2, o_flat2} !== {e2.v, e2.d}) begin
            n_fail++; $display("FAIL mcast_p2: got v=%h d=%h want v=%h d=%h", o_vld2, o_flat2, e2.v, e2.d);
        end
    endtask

    task automatic test_invalid_src();
        rand_in();
        in_valid = 5'b10111;
        set_sel(3, 5, 5, 5, 5);
        tick();
        n_tests += 2;
        if (o_vld1[0] !== 1'b0) begin
            n_fail++; $display("FAIL invsrc_valid: got %b, want 0", o_vld1[0]);
        end
        if (o_flat1[0 +: DW] !== '0) begin
            n_fail++; $display("FAIL invsrc_data: got %h, want 0", o_flat1[0 +: DW]);
        end
    endtask

    task automatic test_sel_err();
        rand_in();
        in_valid = '1;
        // Illegal select during stall must not raise the flag
        stall = 1'b1;
        set_sel(0, 7, 5, 5, 5);
        tick();
        stall = 1'b0;
        n_tests++;
        if (o_err1 !== 1'b0) begin
            n_fail++; $display("FAIL err_stalled: got %b, want 0", o_err1);
        end
        tick();
        n_tests += 3;
        if (o_vld1[1] !== 1'b0 || o_flat1[DW +: DW] !== '0) begin
            n_fail++; $display("FAIL err_out1: got v=%b d=%h, want 0/0", o_vld1[1], o_flat1[DW +: DW]);
        end
        if (o_err1 !== 1'b1 || o_err2 !== 1'b1) begin
            n_fail++; $display("FAIL err_set: got %b/%b, want 1/1", o_err1, o_err2);
        end
        if (o_vld1[0] !== 1'b1) begin
            n_fail++; $display("FAIL err_other: got %b, want 1", o_vld1[0]);
        end
        set_sel(0, 1, 5, 5, 5);
        tick();
        n_tests++;
        if (o_err1 !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky: got %b, want 1", o_err1);
        end
        err_clr = 1'b1;
        set_sel(0, 6, 5, 5, 5);
        tick();
        n_tests++;
        if (o_err1 !== 1'b1 || o_err2 !== 1'b1) begin
            n_fail++; $display("FAIL err_set_wins: got %b/%b, want 1/1", o_err1, o_err2);
        end
        set_sel(0, 1, 5, 5, 5);
        tick();
        err_clr = 1'b0;
        n_tests++;
        if (o_err1 !== 1'b0 || o_err2 !== 1'b0) begin
            n_fail++; $display("FAIL err_clear: got %b/%b, want 0/0", o_err1, o_err2);
        end
    endtask

    task automatic test_stall();
        xact_t e1, e2, held;
        for (int cyc = 0; cyc < 12; cyc++) begin
            stall = (cyc >= 4 && cyc < 7);
            rand_in();
            in_valid = 5'($urandom);
            set_sel($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
                    $urandom_range(0, 5), $urandom_range(0, 5));
            held = exp_at(1);
            tick();
            e1 = exp_at(0);
            e2 = exp_at(1);
            n_tests += 2;
            if ({o_vld1, o_flat1} !== {e1.v, e1.d}) begin
                n_fail++; $display("FAIL stall_p1 cyc %0d: got v=%h d=%h want v=%h d=%h", cyc, o_vld1, o_flat1, e1.v, e1.d);
            end
            if ({o_vld2, o_flat2} !== {e2.v, e2.d}) begin
                n_fail++; $display("FAIL stall_p2 cyc %0d: got v=%h d=%h want v=%h d=%h", cyc, o_vld2, o_flat2, e2.v, e2.d);
            end
            if (stall) begin
                n_tests++;
                if ({o_vld2, o_flat2} !== {held.v, held.d}) begin
                    n_fail++; $display("FAIL stall_frozen cyc %0d: got v=%h want v=%h", cyc, o_vld2, held.v);
                end
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_async_reset();
        xact_t e1, e2;
        rand_in();
        in_valid = '1;
        set_sel(0, 7, 2, 3, 4);
        tick();
        tick();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests += 2;
        if (o_vld1 !== '0 || o_flat1 !== '0 || o_vld2 !== '0 || o_flat2 !== '0) begin
            n_fail++; $display("FAIL areset_out: got v1=%h v2=%h, want 0", o_vld1, o_vld2);
        end
        if (o_err1 !== 1'b0 || o_err2 !== 1'b0) begin
            n_fail++; $display("FAIL areset_err: got %b/%b, want 0/0", o_err1, o_err2);
        end
        @(negedge clk);
        set_sel(1, 2, 3, 4, 0);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            rand_in();
            tick();
            e1 = exp_at(0);
            e2 = exp_at(1);
            n_tests += 2;
            if ({o_vld1, o_flat1} !== {e1.v, e1.d}) begin
                n_fail++; $display("FAIL areset_p1 cyc %0d: got v=%h want v=%h", cyc, o_vld1, e1.v);
            end
            if ({o_vld2, o_flat2} !== {e2.v, e2.d}) begin
                n_fail++; $display("FAIL areset_p2 cyc %0d: got v=%h d=%h want v=%h d=%h", cyc, o_vld2, o_flat2, e2.v, e2.d);
            end
        end
    endtask

    task automatic test_random();
        xact_t e1, e2;
        int s[N];
        for (int cyc = 0; cyc < 300; cyc++) begin
            rand_in();
            in_valid = 5'($urandom);
            for (int o = 0; o < N; o++)
                s[o] = ($urandom_range(0, 19) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
            set_sel(s[0], s[1], s[2], s[3], s[4]);
            stall   = ($urandom_range(0, 3) == 0);
            err_clr = ($urandom_range(0, 5) == 0);
            tick();
            e1 = exp_at(0);
            e2 = exp_at(1);
            n_tests += 3;
            if ({o_vld1, o_flat1} !== {e1.v, e1.d}) begin
                n_fail++; $display("FAIL rand_p1 cyc %0d: got v=%h d=%h want v=%h d=%h", cyc, o_vld1, o_flat1, e1.v, e1.d);
            end
            if ({o_vld2, o_flat2} !== {e2.v, e2.d}) begin
                n_fail++; $display("FAIL rand_p2 cyc %0d: got v=%h d=%h want v=%h d=%h", cyc, o_vld2, o_flat2, e2.v, e2.d);
            end
            if (o_err1 !== exp_err || o_err2 !== exp_err) begin
                n_fail++; $display("FAIL rand_err cyc %0d: got %b/%b want %b", cyc, o_err1, o_err2, exp_err);
            end
        end
        stall   = 1'b0;
        err_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_multicast();
        test_invalid_src();
        test_sel_err();
        test_stall();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
